// File: rtl/ahb_bus_matrix_pkg.sv
// Shared AHB bus-matrix definitions: HTRANS/HBURST encodings, port sentinel,
// and the bundled address-phase control record muxed onto a master interface.
package ahb_bus_matrix_pkg;

    localparam int NUM_SI = 3;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Port index 3 never names an SI, so it doubles as "no owner".
    localparam logic [1:0] NO_PORT = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        mastlock;
    } ahb_ctrl_t;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/ahb_bus_matrix_outstage_m0_if.sv
// Bus bundle between the SI input stages and the MI0 output stage, plus the
// MI0 slave-side signals. slave = output stage view, master = environment view.
interface ahb_bus_matrix_outstage_m0_if;

    localparam int N = ahb_bus_matrix_pkg::NUM_SI;

    logic [N-1:0]       sel_op;
    logic [N-1:0][31:0] addr_op;
    logic [N-1:0][1:0]  trans_op;
    logic [N-1:0]       write_op;
    logic [N-1:0][2:0]  size_op;
    logic [N-1:0][2:0]  burst_op;
    logic [N-1:0][3:0]  prot_op;
    logic [N-1:0][3:0]  master_op;
    logic [N-1:0]       mastlock_op;
    logic [N-1:0][31:0] wdata_op;
    logic [N-1:0]       active_op;

    logic        HSELM;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic [3:0]  HMASTERM;
    logic        HMASTLOCKM;
    logic [31:0] HWDATAM;
    logic        HREADYMUXM;
    logic        HREADYOUTM;

    modport slave (
        input  sel_op, addr_op, trans_op, write_op, size_op, burst_op,
               prot_op, master_op, mastlock_op, wdata_op, HREADYOUTM,
        output active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
               HPROTM, HMASTERM, HMASTLOCKM, HWDATAM, HREADYMUXM
    );

    modport master (
        output sel_op, addr_op, trans_op, write_op, size_op, burst_op,
               prot_op, master_op, mastlock_op, wdata_op, HREADYOUTM,
        input  active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
               HPROTM, HMASTERM, HMASTLOCKM, HWDATAM, HREADYMUXM
    );

endinterface

// File: rtl/ahb_bus_matrix_arb_rr.sv
// Combinational 3-way round-robin pick: search starts one past last_port,
// first requester found wins; NO_PORT when nobody requests.
module ahb_bus_matrix_arb_rr
    import ahb_bus_matrix_pkg::*;
(
    input  logic [NUM_SI-1:0] req,
    input  logic [1:0]        last_port,
    output logic [1:0]        grant_port
);

    logic [1:0] idx;

    always_comb begin
        grant_port = NO_PORT;
        idx        = rr_next(last_port);
        for (int i = 0; i < NUM_SI; i++) begin
            if (grant_port == NO_PORT && req[idx])
                grant_port = idx;
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/ahb_bus_matrix_outstage_m0.sv
// MI0 output stage: arbitrates the SI input stages, muxes the winner's address
// phase onto MI0, keeps burst/locked owners, and steers write data by data-phase owner.
module ahb_bus_matrix_outstage_m0
    import ahb_bus_matrix_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    ahb_bus_matrix_outstage_m0_if.slave bus
);

    ahb_ctrl_t [NUM_SI-1:0] ctrl;
    ahb_ctrl_t              mi;
    logic [NUM_SI-1:0]      req;
    logic [1:0]             last_port, hold_port, data_port, addr_q;
    logic [1:0]             grant_port, addr_port;
    logic                   data_valid, stall_q;
    logic                   hold_release, hold_keep, mi_sel;

    always_comb begin
        for (int n = 0; n < NUM_SI; n++) begin
            req[n]  = bus.sel_op[n] & (bus.trans_op[n] != IDLE);
            ctrl[n] = '{addr:     bus.addr_op[n],
                        trans:    bus.trans_op[n],
                        write:    bus.write_op[n],
                        size:     bus.size_op[n],
                        burst:    bus.burst_op[n],
                        prot:     bus.prot_op[n],
                        master:   bus.master_op[n],
                        mastlock: bus.mastlock_op[n]};
            bus.active_op[n] = (addr_port == 2'(n));
        end
    end

    ahb_bus_matrix_arb_rr u_arb (
        .req        (req),
        .last_port  (last_port),
        .grant_port (grant_port)
    );

    // The holder gives up the bus in the same cycle it shows an unlocked IDLE,
    // so the next requester is granted right after the final burst beat.
    always_comb begin
        hold_release = 1'b0;
        if (hold_port != NO_PORT)
            hold_release = bus.sel_op[hold_port] && (ctrl[hold_port].trans == IDLE)
                           && !ctrl[hold_port].mastlock;
    end

    // During an extended address phase the owner seen at the first wait cycle is replayed.
    always_comb begin
        addr_port = grant_port;
        if (stall_q)
            addr_port = addr_q;
        else if (hold_port != NO_PORT && !hold_release)
            addr_port = hold_port;
    end

    always_comb begin
        mi     = '0;
        mi_sel = 1'b0;
        if (addr_port != NO_PORT) begin
            if (bus.sel_op[addr_port]) begin
                mi     = ctrl[addr_port];
                mi_sel = 1'b1;
            end else begin
                mi.mastlock = ctrl[addr_port].mastlock;
            end
        end
    end

    always_comb begin
        hold_keep = 1'b0;
        if (addr_port != NO_PORT)
            hold_keep = bus.sel_op[addr_port] &&
                        (((ctrl[addr_port].trans != IDLE) && (ctrl[addr_port].burst != HBURST_SINGLE))
                         || ctrl[addr_port].mastlock);
    end

    assign bus.HSELM      = mi_sel;
    assign bus.HADDRM     = mi.addr;
    assign bus.HTRANSM    = mi.trans;
    assign bus.HWRITEM    = mi.write;
    assign bus.HSIZEM     = mi.size;
    assign bus.HBURSTM    = mi.burst;
    assign bus.HPROTM     = mi.prot;
    assign bus.HMASTERM   = mi.master;
    assign bus.HMASTLOCKM = mi.mastlock;

    assign bus.HREADYMUXM = data_valid ? bus.HREADYOUTM : 1'b1;
    assign bus.HWDATAM    = (data_port != NO_PORT) ? bus.wdata_op[data_port] : 32'h0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            last_port  <= 2'd2;
            hold_port  <= NO_PORT;
            data_port  <= NO_PORT;
            data_valid <= 1'b0;
            addr_q     <= NO_PORT;
            stall_q    <= 1'b0;
        end else begin
            addr_q  <= addr_port;
            stall_q <= !bus.HREADYMUXM;
            if (bus.HREADYMUXM) begin
                if (addr_port != NO_PORT) begin
                    last_port <= addr_port;
                    hold_port <= hold_keep ? addr_port : NO_PORT;
                end else begin
                    hold_port <= NO_PORT;
                end
                data_port  <= addr_port;
                data_valid <= (addr_port != NO_PORT) && bus.HTRANSM[1];
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_matrix_outstage_m0.sv
// Vector-table bench for the MI0 output stage with a data-phase owner scoreboard.
module tb_ahb_bus_matrix_outstage_m0;
    import ahb_bus_matrix_pkg::*;

    typedef struct packed {
        logic           rst;
        logic           rdy;
        logic [2:0]     sel;
        logic [2:0][1:0] tr;
        logic [2:0][2:0] bu;
        logic [2:0]     lk;
        logic [2:0]     act;
        logic           rmux;
    } vec_t;

    localparam logic [1:0] TI = IDLE, TB = BUSY, TN = NONSEQ, TS = SEQ;
    localparam logic [2:0] B1 = 3'b000, B4 = 3'b011;
    localparam logic [5:0] IDL = {TI, TI, TI};
    localparam logic [8:0] SGL = {B1, B1, B1};
    localparam logic [8:0] BS1 = {B1, B4, B1};
    localparam logic [8:0] BS2 = {B4, B1, B1};

    logic HCLK = 1'b0;
    logic HRESET;
    int   tests = 0;
    int   fails = 0;
    int   dq[$];

    ahb_bus_matrix_outstage_m0_if bus();

    ahb_bus_matrix_outstage_m0 dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    function automatic vec_t mk(input logic rst, input logic rdy, input logic [2:0] sel,
                                input logic [5:0] tr, input logic [8:0] bu,
                                input logic [2:0] lk, input logic [2:0] act, input logic rmux);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.sel = sel; v.tr = tr; v.bu = bu;
        v.lk = lk; v.act = act; v.rmux = rmux;
        return v;
    endfunction

    function automatic logic [31:0] addr_of(input int n);
        return 32'h1000_0040 + 32'h1000_0000 * n;
    endfunction

    function automatic logic [31:0] wd_of(input int p, input int id);
        logic [3:0] pp;
        logic [7:0] tag;
        pp  = 4'(p);
        tag = 8'(id);
        return (p >= 3) ? 32'h0 : {8'hD0, pp, 12'h000, tag};
    endfunction

    task automatic chk(input int id, input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL v%0d.%s: got %h want %h", id, nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        int   ap;
        logic hs;
        HRESET         = v.rst;
        bus.HREADYOUTM = v.rdy;
        for (int n = 0; n < 3; n++) begin
            bus.sel_op[n]      = v.sel[n];
            bus.trans_op[n]    = v.tr[n];
            bus.burst_op[n]    = v.bu[n];
            bus.mastlock_op[n] = v.lk[n];
            bus.addr_op[n]     = addr_of(n);
            bus.wdata_op[n]    = wd_of(n, id);
            bus.write_op[n]    = 1'b1;
            bus.size_op[n]     = 3'd2;
            bus.prot_op[n]     = 4'h3;
            bus.master_op[n]   = 4'(n);
        end
        ap = 3;
        for (int n = 0; n < 3; n++) if (v.act[n]) ap = n;
        hs = (ap < 3) ? v.sel[ap] : 1'b0;
        @(negedge HCLK);
        chk(id, "active", 32'(bus.active_op), 32'(v.act));
        chk(id, "hsel", 32'(bus.HSELM), 32'(hs));
        chk(id, "htrans", 32'(bus.HTRANSM), hs ? 32'(v.tr[ap]) : 32'(IDLE));
        chk(id, "haddr", bus.HADDRM, hs ? addr_of(ap) : 32'h0);
        chk(id, "hburst", 32'(bus.HBURSTM), hs ? 32'(v.bu[ap]) : 32'h0);
        chk(id, "hlock", 32'(bus.HMASTLOCKM), (ap < 3) ? 32'(v.lk[ap]) : 32'h0);
        chk(id, "hreadymux", 32'(bus.HREADYMUXM), 32'(v.rmux));
        if (dq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL v%0d.scoreboard: got empty want entry", id);
        end else begin
            chk(id, "hwdata", bus.HWDATAM, wd_of(dq[0], id));
        end
        @(posedge HCLK);
        #1;
        if (v.rst) begin
            dq.delete();
            dq.push_back(3);
        end else if (v.rmux) begin
            if (dq.size() != 0) void'(dq.pop_front());
            dq.push_back(ap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[$];
        vec_t hv[$];
        // reset state and idle with a stalled slave (no data phase pending)
        tv.push_back(mk(0, 1, 3'b000, IDL, SGL, 3'b000, 3'b000, 1));
        tv.push_back(mk(0, 0, 3'b000, IDL, SGL, 3'b000, 3'b000, 1));
        // SI0 and SI1 together, last_port=2: SI0 then SI1
        tv.push_back(mk(0, 1, 3'b011, {TI, TN, TN}, SGL, 3'b000, 3'b001, 1));
        tv.push_back(mk(0, 1, 3'b010, {TI, TN, TI}, SGL, 3'b000, 3'b010, 1));
        tv.push_back(mk(0, 1, 3'b000, IDL, SGL, 3'b000, 3'b000, 1));
        // SI1 INCR4 while SI2 requests; SI2 granted right after the last SEQ
        tv.push_back(mk(0, 1, 3'b010, {TI, TN, TI}, BS1, 3'b000, 3'b010, 1));
        tv.push_back(mk(0, 1, 3'b110, {TN, TS, TI}, BS1, 3'b000, 3'b010, 1));
        tv.push_back(mk(0, 1, 3'b110, {TN, TS, TI}, BS1, 3'b000, 3'b010, 1));
        tv.push_back(mk(0, 1, 3'b110, {TN, TS, TI}, BS1, 3'b000, 3'b010, 1));
        tv.push_back(mk(0, 1, 3'b110, {TN, TI, TI}, BS1, 3'b000, 3'b100, 1));
        // three wait states behind SI2's write; SI0 arrives mid-wait and must wait
        tv.push_back(mk(0, 0, 3'b100, {TN, TI, TI}, SGL, 3'b000, 3'b100, 0));
        tv.push_back(mk(0, 0, 3'b101, {TN, TI, TN}, SGL, 3'b000, 3'b100, 0));
        tv.push_back(mk(0, 0, 3'b101, {TN, TI, TN}, SGL, 3'b000, 3'b100, 0));
        tv.push_back(mk(0, 1, 3'b101, {TN, TI, TN}, SGL, 3'b000, 3'b100, 1));
        tv.push_back(mk(0, 1, 3'b001, {TI, TI, TN}, SGL, 3'b000, 3'b001, 1));
        // SI0 locked sequence blocks SI1 until IDLE with lock dropped
        tv.push_back(mk(0, 1, 3'b001, {TI, TI, TN}, SGL, 3'b001, 3'b001, 1));
        tv.push_back(mk(0, 1, 3'b011, {TI, TN, TN}, SGL, 3'b001, 3'b001, 1));
        tv.push_back(mk(0, 1, 3'b011, {TI, TN, TI}, SGL, 3'b001, 3'b001, 1));
        tv.push_back(mk(0, 1, 3'b011, {TI, TN, TI}, SGL, 3'b000, 3'b010, 1));
        tv.push_back(mk(0, 1, 3'b000, IDL, SGL, 3'b000, 3'b000, 1));
        // reset in the middle of an SI1 burst
        tv.push_back(mk(0, 1, 3'b010, {TI, TN, TI}, BS1, 3'b000, 3'b010, 1));
        tv.push_back(mk(0, 1, 3'b010, {TI, TS, TI}, BS1, 3'b000, 3'b010, 1));
        tv.push_back(mk(1, 1, 3'b010, {TI, TS, TI}, BS1, 3'b000, 3'b010, 1));
        tv.push_back(mk(0, 0, 3'b000, IDL, SGL, 3'b000, 3'b000, 1));
        tv.push_back(mk(0, 1, 3'b011, {TI, TS, TN}, BS1, 3'b000, 3'b001, 1));
        tv.push_back(mk(0, 1, 3'b000, IDL, SGL, 3'b000, 3'b000, 1));

        HRESET         = 1'b1;
        bus.HREADYOUTM = 1'b1;
        bus.sel_op     = '0;
        bus.trans_op   = '0;
        bus.burst_op   = '0;
        bus.mastlock_op = '0;
        bus.addr_op    = '0;
        bus.wdata_op   = '0;
        bus.write_op   = '0;
        bus.size_op    = '0;
        bus.prot_op    = '0;
        bus.master_op  = '0;
        dq.push_back(3);
        repeat (2) @(posedge HCLK);
        #1;

        for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

        // BUSY inside an SI2 burst, then SI2 drops sel while holding with lock
        hv.push_back(mk(0, 1, 3'b100, {TN, TI, TI}, BS2, 3'b000, 3'b100, 1));
        hv.push_back(mk(0, 1, 3'b101, {TB, TI, TN}, BS2, 3'b000, 3'b100, 1));
        hv.push_back(mk(0, 1, 3'b001, {TI, TI, TN}, BS2, 3'b100, 3'b100, 1));
        hv.push_back(mk(0, 1, 3'b001, {TI, TI, TN}, SGL, 3'b000, 3'b001, 1));
        hv.push_back(mk(0, 1, 3'b000, IDL, SGL, 3'b000, 3'b000, 1));
        for (int k = 0; k < hv.size(); k++) apply(hv[k], 100 + k);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_bus_matrix_outstage_m0.md
# ahb_bus_matrix_outstage_m0

Output stage for master interface MI0 of the AHB bus matrix. It is the counterpart of the per-slave-port decoders, which raise `sel_opN` towards this stage. It arbitrates between up to three slave-interface (SI) input stages competing for MI0 and drives the selected SI's address-phase and control signals onto MI0. It tracks the data-phase owner to steer write data, and returns `active_opN` so each decoder knows whether its transfer has been accepted.

## Interface
- `NUM_SI`, 3: number of competing input stages (fixed at 3 in this build).
- `HCLK` in 1: AHB system clock.
- `HRESET` in 1: reset, synchronous, active-high.
- `sel_opN` in 1 (N=0..2): decoder select for MI0 from SI N.
- `addr_opN` in 32: HADDR from SI N.
- `trans_opN` in 2: HTRANS from SI N.
- `write_opN` in 1, `size_opN` in 3, `burst_opN` in 3, `prot_opN` in 4, `master_opN` in 4: control from SI N.
- `mastlock_opN` in 1: HMASTLOCK from SI N.
- `wdata_opN` in 32: HWDATA from SI N.
- `active_opN` out 1: SI N owns the MI0 address phase this cycle.
- `HSELM` out 1, `HADDRM` out 32, `HTRANSM` out 2, `HWRITEM` out 1, `HSIZEM` out 3, `HBURSTM` out 3, `HPROTM` out 4, `HMASTERM` out 4, `HMASTLOCKM` out 1: MI0 address phase.
- `HWDATAM` out 32: MI0 write data.
- `HREADYMUXM` out 1: HREADY to the MI0 slave.
- `HREADYOUTM` in 1: slave HREADYOUT.

## Operation
- **Request.** `req[N] = sel_opN & (trans_opN != IDLE)`.
- **State registers**
  - `last_port[1:0]`: most recent grant. Reset value 2.
  - `hold_port[1:0]`: owner of a burst or locked sequence. `NO_PORT`=3 when none.
  - `data_port[1:0]`: data-phase owner. Reset value `NO_PORT`.
  - `data_valid`: a data phase is pending. Reset value 0.
- **Address owner (combinational, `addr_port`)**
  - If `hold_port != NO_PORT`: `addr_port = hold_port`.
  - Otherwise: round-robin pick among `req`, starting at `last_port+1` mod 3.
  - If no request: `NO_PORT`.
- **Update when `HREADYMUXM`=1 and `addr_port != NO_PORT`**
  - `last_port <= addr_port`.
  - `hold_port <= addr_port` if the owner's next beat must stay: `trans` is NONSEQ/SEQ/BUSY with `burst != SINGLE`, or `mastlock`=1. Otherwise `hold_port <= NO_PORT`.
  - Hold is released when the holding SI presents IDLE with `mastlock`=0, or drops `sel`.
- **MI0 address outputs**
  - When `addr_port` is a valid SI: mux that SI's address and control onto MI0.
  - When `addr_port = NO_PORT`: `HSELM`=0, `HTRANSM`=IDLE, `HADDRM`=0, all other control outputs 0, `HMASTLOCKM`=0.
  - If a held owner has `sel`=0, drive IDLE with `HMASTLOCKM` kept at the owner's value.
- **`active_opN`** = (`addr_port` == N). Only one may be high at a time.
- **Data phase.** On `HREADYMUXM`=1:
  - `data_port <= addr_port`.
  - `data_valid <= (addr_port != NO_PORT) & (HTRANSM` is NONSEQ or SEQ`)`.
- **`HWDATAM`** = `wdata_op[data_port]`, or 0 when `data_port = NO_PORT`.
- **`HREADYMUXM`** = `data_valid ? HREADYOUTM : 1'b1`.

## Timing
- Address path from SI to MI0 is combinational: zero-cycle latency after grant.
- Arbitration decisions take effect only on `HCLK` edges where `HREADYMUXM`=1. While `HREADYMUXM`=0, `addr_port` and all registers are frozen.
- The data phase follows the address phase by exactly one accepted cycle. `HWDATAM` switches on the same edge as `data_port`.
- **Simultaneous requests:** the round-robin order decides, with no starvation. Each requester is granted within 3 arbitration points once no hold is active.
- **Request arriving during another SI's burst or locked sequence:** `active_opN`=0 until the hold is released. The losing SI's input stage holds its transfer.
- **BUSY inside a burst:** the owner is retained and BUSY is passed through.
- **Reset mid-transfer:** on `HRESET`=1 at an edge, all registers return to their reset values in that cycle. Outputs show `NO_PORT`/IDLE from the next cycle.

## Structure
- Shared package `ahb_bus_matrix_pkg` holds:
  - HTRANS constants: `IDLE`=2'b00, `BUSY`=01, `NONSEQ`=10, `SEQ`=11.
  - `HBURST_SINGLE`=3'b000.
  - `NO_PORT`=2'b11.
- Sub-module `ahb_bus_matrix_arb_rr`: a combinational 3-way round-robin pick taking `req[2:0]` and `last_port`, returning `grant_port`.
- The top level holds the hold, data-phase registers and muxes.

## Test plan
- After reset, no requests → `HTRANSM`=00, `HSELM`=0, `HREADYMUXM`=1, all `active_opN`=0.
- SI0 and SI1 NONSEQ SINGLE together, `last_port`=2 → SI0 granted first, then SI1. `HWDATAM` = `wdata_op0`, then `wdata_op1`, each in its data cycle.
- SI1 runs an INCR4 (NONSEQ, SEQ×3) with SI2 requesting throughout → `active_op2`=0 for 4 beats. SI2 is granted on the beat after SI1's last SEQ.
- Slave holds `HREADYOUTM`=0 for 3 cycles during a SI2 write → `HREADYMUXM`=0, and `addr_port`, `HADDRM` and `HWDATAM` stay stable. A new SI0 request is not granted until ready.
- SI0 locked sequence (`mastlock`=1, two NONSEQ, then IDLE with lock) with SI1 requesting → SI1 is blocked until SI0 presents IDLE with `mastlock`=0.
- `HRESET` asserted during a SI1 burst data phase → next cycle: `data_valid`=0, `hold_port`=3, `HTRANSM`=IDLE.
